// File: rtl/rob_commit_ctl_pkg.sv
// Shared sizing, types and helpers for the ROB commit controller and issue logic.
package rob_commit_ctl_pkg;

  localparam int IQ_SIZE      = 8;  // IQ/ROB slots, power of two
  localparam int PTR_W        = 3;  // log2(IQ_SIZE)
  localparam int COMMIT_WIDTH = 2;  // max slots retired per cycle
  localparam int WRITE_PORTS  = 2;  // finish ports, one per ROB write bus

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  // Age of a slot relative to the head; wraps naturally because IQ_SIZE is a power of two.
  function automatic ptr_t rel_age(input ptr_t pos, input ptr_t head);
    return ptr_t'(pos - head);
  endfunction

  // 32-bit saturating add used by the optional commit statistics.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hffff_ffff : sum[31:0];
  endfunction

endpackage

// File: rtl/rob_commit_select.sv
// Commit window selection: walks from the head through up to COMMIT_WIDTH
// occupied slots and stops at the first slot that is neither done nor squashed.
module rob_commit_select
  import rob_commit_ctl_pkg::*;
(
  input  logic [PTR_W-1:0]   head,
  input  logic [PTR_W:0]     count,
  input  logic [IQ_SIZE-1:0] ret_vec,
  output logic [PTR_W:0]     k,
  output logic [IQ_SIZE-1:0] commitbit
);

  logic run;
  ptr_t idx;

  // Ripple chain: each window position retires only if every older position does.
  always_comb begin
    k         = '0;
    commitbit = '0;
    run       = 1'b1;
    idx       = head;
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      idx = ptr_t'(head + ptr_t'(j));
      run = run && (cnt_t'(j) < count) && ret_vec[idx];
      if (run) begin
        commitbit[idx] = 1'b1;
        k              = k + cnt_t'(1);
      end
    end
  end

endmodule

// File: rtl/rob_commit_ctl.sv
// In-order commit scheduler for the versioned register file.
// Tracks each IQ/ROB slot from allocation through finish/squash to retirement
// and drives commitbit/flushbit for the ROB->regfile commit on the next edge.
// Optional feature: define COMMIT_STATS_EN to add saturating commit/flush/stall counters.
module rob_commit_ctl
  import rob_commit_ctl_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_valid,
  output logic                         alloc_ready,
  output logic [PTR_W-1:0]             alloc_pos,
  input  logic [WRITE_PORTS-1:0]       finish_we,
  input  logic [WRITE_PORTS*PTR_W-1:0] finish_pos,
  input  logic                         flush_req,
  input  logic [PTR_W-1:0]             flush_pos,
  output logic [IQ_SIZE-1:0]           commitbit,
  output logic [IQ_SIZE-1:0]           flushbit,
  output logic [PTR_W-1:0]             head_pos,
  output logic [PTR_W:0]               count
`ifdef COMMIT_STATS_EN
  ,
  output logic [31:0]                  stat_commit,
  output logic [31:0]                  stat_flush,
  output logic [31:0]                  stat_stall
`endif
);

  // Handshake: an allocation happens on a clock edge where alloc_valid && alloc_ready;
  // alloc_ready never depends on alloc_valid, and the granted slot is alloc_pos.

  ptr_t                head_q, tail_q;
  cnt_t                count_q;
  logic [IQ_SIZE-1:0]  valid_q, done_q, sq_q;

  logic [IQ_SIZE-1:0]  valid_n, done_n, sq_n;
  logic [IQ_SIZE-1:0]  ret_vec, fin_vec, squash_vec;
  logic                alloc_fire, flush_ok;
  ptr_t                flush_age;
  cnt_t                k;

  assign ret_vec = valid_q & (done_q | sq_q);

  rob_commit_select u_select (
    .head      (head_q),
    .count     (count_q),
    .ret_vec   (ret_vec),
    .k         (k),
    .commitbit (commitbit)
  );

  assign alloc_ready = !rst && !flush_req && (count_q < cnt_t'(IQ_SIZE));
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_pos   = tail_q;
  assign flushbit    = sq_q;
  assign head_pos    = head_q;
  assign count       = count_q;

  // A flush is honoured only if the mispredicting slot is live and not already squashed.
  assign flush_ok  = flush_req && valid_q[flush_pos] && !sq_q[flush_pos];
  assign flush_age = rel_age(flush_pos, head_q);

  // Finish requests and squash targets, both evaluated against pre-edge state.
  always_comb begin
    fin_vec    = '0;
    squash_vec = '0;
    for (int p = 0; p < WRITE_PORTS; p++) begin
      if (finish_we[p] && valid_q[finish_pos[p*PTR_W +: PTR_W]] &&
          !sq_q[finish_pos[p*PTR_W +: PTR_W]])
        fin_vec[finish_pos[p*PTR_W +: PTR_W]] = 1'b1;
    end
    for (int i = 0; i < IQ_SIZE; i++) begin
      if (flush_ok && valid_q[i] && (rel_age(ptr_t'(i), head_q) > flush_age))
        squash_vec[i] = 1'b1;
    end
  end

  // Next per-slot state: squash beats finish, retirement clears, allocation seeds the tail.
  always_comb begin
    valid_n = valid_q;
    done_n  = done_q;
    sq_n    = sq_q;
    for (int i = 0; i < IQ_SIZE; i++) begin
      if (squash_vec[i])
        sq_n[i] = 1'b1;
      if (fin_vec[i] && !squash_vec[i])
        done_n[i] = 1'b1;
      if (commitbit[i]) begin
        valid_n[i] = 1'b0;
        done_n[i]  = 1'b0;
        sq_n[i]    = 1'b0;
      end
    end
    if (alloc_fire) begin
      valid_n[tail_q] = 1'b1;
      done_n[tail_q]  = 1'b0;
      sq_n[tail_q]    = 1'b0;
    end
  end

  // Pointer, occupancy and slot-state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
      sq_q    <= '0;
    end else begin
      head_q  <= ptr_t'(head_q + k);
      tail_q  <= ptr_t'(tail_q + ptr_t'(alloc_fire));
      count_q <= count_q + cnt_t'(alloc_fire) - k;
      valid_q <= valid_n;
      done_q  <= done_n;
      sq_q    <= sq_n;
    end
  end

`ifdef COMMIT_STATS_EN
  cnt_t sq_ret;

  // Number of squashed slots inside this cycle's commit window.
  always_comb begin
    sq_ret = '0;
    for (int i = 0; i < IQ_SIZE; i++)
      sq_ret = sq_ret + cnt_t'(commitbit[i] & sq_q[i]);
  end

  // Saturating retirement statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_commit <= '0;
      stat_flush  <= '0;
      stat_stall  <= '0;
    end else begin
      stat_commit <= sat_add32(stat_commit, 32'(k - sq_ret));
      stat_flush  <= sat_add32(stat_flush, 32'(sq_ret));
      stat_stall  <= sat_add32(stat_stall, 32'((count_q != '0) && (k == '0)));
    end
  end
`endif

endmodule

// File: tb/tb_rob_commit_ctl.sv
// Directed bench for rob_commit_ctl: reset, in-order commit, full/wrap,
// wrapped flush drain, finish/flush collision and mid-drain reset.
module tb_rob_commit_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_valid;
  logic       alloc_ready;
  logic [2:0] alloc_pos;
  logic [1:0] finish_we;
  logic [5:0] finish_pos;
  logic       flush_req;
  logic [2:0] flush_pos;
  logic [7:0] commitbit;
  logic [7:0] flushbit;
  logic [2:0] head_pos;
  logic [3:0] count;
`ifdef COMMIT_STATS_EN
  logic [31:0] stat_commit, stat_flush, stat_stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  rob_commit_ctl dut (
    .clk         (clk),
    .rst         (rst),
    .alloc_valid (alloc_valid),
    .alloc_ready (alloc_ready),
    .alloc_pos   (alloc_pos),
    .finish_we   (finish_we),
    .finish_pos  (finish_pos),
    .flush_req   (flush_req),
    .flush_pos   (flush_pos),
    .commitbit   (commitbit),
    .flushbit    (flushbit),
    .head_pos    (head_pos),
    .count       (count)
`ifdef COMMIT_STATS_EN
    ,
    .stat_commit (stat_commit),
    .stat_flush  (stat_flush),
    .stat_stall  (stat_stall)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    alloc_valid = 1'b0;
    finish_we   = 2'b00;
    finish_pos  = 6'd0;
    flush_req   = 1'b0;
    flush_pos   = 3'd0;
  endtask

  initial begin
    // 1. Reset held two cycles with traffic driven
    rst = 1'b1; idle();
    alloc_valid = 1'b1; finish_we = 2'b11;
    tick(); tick();
    chk("rst_commitbit", commitbit, 0);
    chk("rst_flushbit", flushbit, 0);
    chk("rst_head", head_pos, 0);
    chk("rst_count", count, 0);
    chk("rst_ready", alloc_ready, 0);
    rst = 1'b0; idle(); #1;
    chk("post_rst_ready", alloc_ready, 1);
    chk("post_rst_count", count, 0);

    // 2. Allocate 0,1,2; finish 1 then 0
    alloc_valid = 1'b1; #1;
    chk("t2_alloc_pos0", alloc_pos, 0);
    tick(); chk("t2_alloc_pos1", alloc_pos, 1);
    tick(); chk("t2_alloc_pos2", alloc_pos, 2);
    tick(); alloc_valid = 1'b0;
    chk("t2_count3", count, 3);
    finish_we = 2'b01; finish_pos = {3'd0, 3'd1};
    tick(); idle();
    chk("t2_no_commit_slot0_pending", commitbit, 0);
    finish_we = 2'b01; finish_pos = {3'd0, 3'd0};
    tick(); idle();
    chk("t2_commitbit_03", commitbit, 8'h03);
    tick();
    chk("t2_head2", head_pos, 2);
    chk("t2_count1", count, 1);
    chk("t2_slot2_waits", commitbit, 0);
    finish_we = 2'b01; finish_pos = {3'd0, 3'd2};
    tick(); idle();
    chk("t2_commitbit_04", commitbit, 8'h04);
    tick();
    chk("t2_empty_count", count, 0);
    chk("t2_empty_head", head_pos, 3);

    // 3. Fill all 8 slots starting at tail=3, wrapping 7->0
    alloc_valid = 1'b1;
    tick(); tick(); tick(); tick();
    chk("t3_tail7", alloc_pos, 7);
    tick();
    chk("t3_wrap_tail0", alloc_pos, 0);
    tick(); tick(); tick();
    chk("t3_full_count", count, 8);
    chk("t3_full_not_ready", alloc_ready, 0);
    finish_we = 2'b01; finish_pos = {3'd0, 3'd3};
    tick(); finish_we = 2'b00;
    chk("t3_commit_head", commitbit, 8'h08);
    chk("t3_ready_pre_commit", alloc_ready, 0);
    chk("t3_count_still8", count, 8);
    tick(); alloc_valid = 1'b0; #1;
    chk("t3_count7", count, 7);
    chk("t3_head4", head_pos, 4);
    chk("t3_ready_again", alloc_ready, 1);
    chk("t3_tail_held3", alloc_pos, 3);
    finish_we = 2'b11; finish_pos = {3'd4, 3'd5};
    tick(); idle();
    chk("t3_commit_pair", commitbit, 8'h30);
    tick();
    chk("t3_head6", head_pos, 6);
    chk("t3_count5", count, 5);

    // 4. Wrapped flush: head=6, tail=3, flush_pos=7
    flush_req = 1'b1; flush_pos = 3'd7; alloc_valid = 1'b1; #1;
    chk("t4_flush_blocks_alloc", alloc_ready, 0);
    tick(); idle();
    chk("t4_flushbit", flushbit, 8'h07);
    chk("t4_count_kept", count, 5);
    chk("t4_no_commit", commitbit, 0);
    finish_we = 2'b11; finish_pos = {3'd6, 3'd7};
    tick(); idle();
    chk("t4_commit_67", commitbit, 8'hc0);
    tick();
    chk("t4_head0", head_pos, 0);
    chk("t4_count3", count, 3);
    chk("t4_drain_01", commitbit, 8'h03);
    chk("t4_drain_01_fb", flushbit, 8'h07);
    tick();
    chk("t4_drain_2", commitbit, 8'h04);
    chk("t4_drain_2_fb", flushbit, 8'h04);
    tick();
    chk("t4_drained_count", count, 0);
    chk("t4_drained_head", head_pos, 3);
    chk("t4_drained_fb", flushbit, 0);

    // 5. Finish on both ports to slot 4 while flushing at 3
    alloc_valid = 1'b1;
    tick(); tick(); tick();
    alloc_valid = 1'b0;
    finish_we = 2'b01; finish_pos = {3'd0, 3'd3};
    tick();
    finish_we = 2'b11; finish_pos = {3'd4, 3'd4};
    flush_req = 1'b1; flush_pos = 3'd3; #1;
    chk("t5_slot3_commit", commitbit, 8'h08);
    tick(); idle();
    chk("t5_sq_commit", commitbit, 8'h30);
    chk("t5_sq_flushbit", flushbit, 8'h30);
    chk("t5_head4", head_pos, 4);
    chk("t5_count2", count, 2);
    tick();
    chk("t5_empty", count, 0);
    chk("t5_head6", head_pos, 6);

    // 6. Ignored requests on empty queue, then reset mid-drain
    flush_req = 1'b1; flush_pos = 3'd7;
    finish_we = 2'b01; finish_pos = {3'd0, 3'd7};
    tick(); idle();
    chk("t6_ign_flush", flushbit, 0);
    chk("t6_ign_count", count, 0);
    alloc_valid = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    alloc_valid = 1'b0;
    chk("t6_count5", count, 5);
    finish_we = 2'b11; finish_pos = {3'd6, 3'd7};
    tick();
    finish_we = 2'b11; finish_pos = {3'd0, 3'd1};
    chk("t6_commit_67", commitbit, 8'hc0);
    tick();
    finish_we = 2'b01; finish_pos = {3'd0, 3'd2};
    chk("t6_commit_01", commitbit, 8'h03);
    rst = 1'b1;
    tick();
    chk("t6_rst_count", count, 0);
    chk("t6_rst_head", head_pos, 0);
    chk("t6_rst_commitbit", commitbit, 0);
    chk("t6_rst_flushbit", flushbit, 0);
    rst = 1'b0; idle(); #1;
    chk("t6_ready", alloc_ready, 1);
    chk("t6_tail0", alloc_pos, 0);
`ifdef COMMIT_STATS_EN
    chk("t6_stat_commit", stat_commit, 0);
    chk("t6_stat_flush", stat_flush, 0);
    chk("t6_stat_stall", stat_stall, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
